// File: rtl/gerador_senha.sv
// Code-entry transmitter: plays a stored digit sequence onto numero/insere and grades the lock's led response.
// Optional `GERADOR_RETRY_EN`: re-dial up to MAX_RETRY extra times before reporting fail.
module gerador_senha #(
  parameter int N_DIGITS  = 7,
  parameter int GAP_CYC   = 1,
  parameter int RESP_WAIT = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       start,
  input  logic       led,
  output logic [3:0] numero,
  output logic       insere,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail
);

  localparam int CMAX = (GAP_CYC > RESP_WAIT) ? GAP_CYC : RESP_WAIT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, GAP, WAIT_RESP, DONE, REGAP
  } state_t;

  state_t          state, state_n;
  logic [2:0]      idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      numero_n;
  logic            insere_n, done_n, pass_n, fail_n;
  logic [3:0]      mem [N_DIGITS];
  logic            wr_ok;

`ifdef GERADOR_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry, retry_n;
`endif

  assign busy  = (state != IDLE);
  assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < 4'(N_DIGITS));

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    numero_n = numero;
    insere_n = 1'b0;
    done_n   = 1'b0;
    pass_n   = pass;
    fail_n   = fail;
`ifdef GERADOR_RETRY_EN
    retry_n  = retry;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETUP;
          idx_n   = '0;
          pass_n  = 1'b0;
          fail_n  = 1'b0;
`ifdef GERADOR_RETRY_EN
          retry_n = '0;
`endif
        end
      end
      SETUP: begin
        numero_n = mem[idx];
        state_n  = STROBE;
      end
      STROBE: begin
        insere_n = 1'b1;
        cnt_n    = CW'(GAP_CYC - 1);
        state_n  = GAP;
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (idx < 3'(N_DIGITS - 1)) begin
          idx_n   = idx + 3'd1;
          state_n = SETUP;
        end else begin
          cnt_n   = CW'(RESP_WAIT - 1);
          state_n = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (led) begin
          pass_n  = 1'b1;
          state_n = DONE;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
`ifdef GERADOR_RETRY_EN
          if (retry < RW'(MAX_RETRY)) begin
            retry_n = retry + 1'b1;
            cnt_n   = CW'(GAP_CYC - 1);
            state_n = REGAP;
          end else begin
            fail_n  = 1'b1;
            state_n = DONE;
          end
`else
          fail_n  = 1'b1;
          state_n = DONE;
`endif
        end
      end
      REGAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          idx_n   = '0;
          state_n = SETUP;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      numero <= '0;
      insere <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
      fail   <= 1'b0;
      for (int unsigned i = 0; i < N_DIGITS; i++) mem[i] <= '0;
`ifdef GERADOR_RETRY_EN
      retry  <= '0;
`endif
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      numero <= numero_n;
      insere <= insere_n;
      done   <= done_n;
      pass   <= pass_n;
      fail   <= fail_n;
      if (wr_ok) mem[wr_addr] <= wr_data;
`ifdef GERADOR_RETRY_EN
      retry  <= retry_n;
`endif
    end
  end

endmodule
